// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: colour source for the 640x480 timing stage.
// Draws one of four test patterns. A debounced button steps the pattern, and
// the step is applied only at a frame boundary (vsync rise), so a frame is
// never torn. The pixel path is combinational so that the timing stage can use
// the colour in the same cycle it presents the address.
module vga_pattern_gen #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SCROLL_STEP     = 4
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        btn,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        valid,
  input  logic        vsync,
  output logic [23:0] vga_data,
  output logic [1:0]  mode
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          btn_s1, btn_s2;
  logic [CW-1:0] deb_cnt;
  logic          deb_lvl, deb_lvl_d;
  logic          vsync_d;
  logic          pending;
  logic [9:0]    offset;

  logic          press_evt, frame_start;
  logic [10:0]   off_sum, off_next;
  logic [10:0]   h_sum, h_scr;
  logic [2:0]    pal_idx;

  // Index of the bar of width w that contains x; a compare chain, no divider.
  function automatic logic [2:0] bar_idx(input logic [10:0] x, input logic [10:0] w);
    logic [2:0] idx;
    idx = 3'd7;
    for (int i = 7; i >= 1; i--)
      if (x < 11'(i) * w) idx = 3'(i - 1);
    return idx;
  endfunction

  // Eight-colour palette, brightest first, ending in black.
  function automatic logic [23:0] palette(input logic [2:0] p);
    logic [23:0] c;
    case (p)
      3'd0:    c = 24'hFFFFFF;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FFFF;
      3'd3:    c = 24'h00FF00;
      3'd4:    c = 24'hFF00FF;
      3'd5:    c = 24'hFF0000;
      3'd6:    c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  assign press_evt   = deb_lvl & ~deb_lvl_d;
  assign frame_start = vsync & ~vsync_d;

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s2 <= btn_s1;
    end
  end

  // Debounce: accept a new level only after it has been stable DEBOUNCE_CYCLES cycles.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      deb_cnt   <= '0;
      deb_lvl   <= 1'b0;
      deb_lvl_d <= 1'b0;
    end else begin
      deb_lvl_d <= deb_lvl;
      if (btn_s2 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == CNT_MAX) begin
        deb_lvl <= btn_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // Delayed vsync for rising-edge (frame start) detection.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) vsync_d <= 1'b0;
    else       vsync_d <= vsync;
  end

  // Next scroll offset, wrapped into 0..639.
  always_comb begin
    off_sum  = 11'(offset) + 11'(SCROLL_STEP);
    off_next = (off_sum >= 11'd640) ? off_sum - 11'd640 : off_sum;
  end

  // Mode and offset only move at frame start; a press seen on that same cycle counts.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      mode    <= 2'd0;
      pending <= 1'b0;
      offset  <= '0;
    end else if (frame_start) begin
      offset  <= off_next[9:0];
      pending <= 1'b0;
      if (pending || press_evt) mode <= mode + 2'd1;
    end else if (press_evt) begin
      pending <= 1'b1;
    end
  end

  // Per-pixel colour, zero latency from the coordinates.
  always_comb begin
    pal_idx = 3'd7;
    h_sum   = 11'(h_addr) + 11'(offset);
    h_scr   = (h_sum >= 11'd640) ? h_sum - 11'd640 : h_sum;
    case (mode)
      2'd0:    pal_idx = bar_idx(11'(h_addr), 11'd80);
      2'd1:    pal_idx = bar_idx(11'(v_addr), 11'd60);
      2'd2:    pal_idx = (h_addr[5] ^ v_addr[5]) ? 3'd7 : 3'd0;
      default: pal_idx = bar_idx(h_scr, 11'd80);
    endcase
    if (h_addr > 10'd639 || v_addr > 10'd479) pal_idx = 3'd7;
    vga_data = (valid && !reset) ? palette(pal_idx) : 24'h000000;
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: directed scenarios plus random pixels and button
// activity, checked against an arithmetic model of the patterns.
module tb_vga_pattern_gen;
  localparam int DEB  = 4;
  localparam int STEP = 4;

  logic        pclk = 1'b0;
  logic        reset, btn, valid, vsync;
  logic [9:0]  h_addr, v_addr;
  logic [23:0] vga_data;
  logic [1:0]  mode;

  int n_vec = 0, n_err = 0;
  int m_mode, m_off;
  bit m_pend;

  always #20 pclk = ~pclk;

  vga_pattern_gen #(.DEBOUNCE_CYCLES(DEB), .SCROLL_STEP(STEP)) dut (
    .pclk(pclk), .reset(reset), .btn(btn), .h_addr(h_addr), .v_addr(v_addr),
    .valid(valid), .vsync(vsync), .vga_data(vga_data), .mode(mode)
  );

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] pal(input int p);
    case (p)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] ref_px(input int md, input int off, input int h,
                                         input int v, input bit vl);
    if (!vl) return 24'h0;
    if (h > 639 || v > 479) return pal(7);
    case (md)
      0: return pal(h / 80);
      1: return pal(v / 60);
      2: return (((h / 32) + (v / 32)) % 2 == 0) ? pal(0) : pal(7);
      default: return pal(((h + off) % 640) / 80);
    endcase
  endfunction

  task automatic tick();
    @(posedge pclk); #1;
  endtask

  // Hold btn for len cycles, then a long quiet gap so the level settles back low.
  task automatic press(input int len);
    btn = 1'b1;
    repeat (len) tick();
    btn = 1'b0;
    repeat (DEB + 6) tick();
    if (len >= DEB) m_pend = 1'b1;
  endtask

  // One vsync rise; the model applies the frame-boundary rules.
  task automatic frame();
    vsync = 1'b0;
    tick(); tick();
    vsync = 1'b1;
    tick();
    if (m_pend) m_mode = (m_mode + 1) % 4;
    m_pend = 1'b0;
    m_off  = (m_off + STEP) % 640;
    chk("mode", 24'(mode), 24'(m_mode));
  endtask

  task automatic pix_k(input int h, input int v, input bit vl,
                       input logic [23:0] exp, input string tag);
    h_addr = 10'(h); v_addr = 10'(v); valid = vl;
    #2;
    chk(tag, vga_data, exp);
  endtask

  task automatic rand_pix(input int n);
    int h, v; bit vl;
    for (int i = 0; i < n; i++) begin
      h  = $urandom_range(0, 700);
      v  = $urandom_range(0, 520);
      vl = ($urandom_range(0, 7) != 0);
      pix_k(h, v, vl, ref_px(m_mode, m_off, h, v, vl), "rand_px");
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_off = 0; m_pend = 1'b0;
  endtask

  initial begin
    int guard;
    model_reset();
    reset = 1'b1; btn = 1'b0; vsync = 1'b0;
    valid = 1'b1; h_addr = 10'd85; v_addr = 10'd0;

    // Reset state
    repeat (3) tick();
    chk("rst_mode", 24'(mode), 24'd0);
    chk("rst_data", vga_data, 24'h000000);
    reset = 1'b0;
    tick();
    chk("post_rst_85", vga_data, 24'hFFFF00);
    rand_pix(30);

    // Short glitch produces no step; a long press steps once
    press(3);
    frame();
    chk("glitch_mode", 24'(mode), 24'd0);
    press(10);
    frame();
    chk("press_mode", 24'(mode), 24'd1);

    // Horizontal bars
    pix_k(0, 59, 1'b1, 24'hFFFFFF, "hb_59");
    pix_k(0, 60, 1'b1, 24'hFFFF00, "hb_60");
    pix_k(0, 479, 1'b1, 24'h000000, "hb_479");
    pix_k(300, 200, 1'b0, 24'h000000, "hb_novalid");
    rand_pix(30);

    // Two presses before one frame start advance by one
    press(6);
    press(7);
    frame();
    chk("two_press", 24'(mode), 24'd2);
    pix_k(31, 0, 1'b1, 24'hFFFFFF, "cb_31_0");
    pix_k(32, 0, 1'b1, 24'h000000, "cb_32_0");
    pix_k(32, 32, 1'b1, 24'hFFFFFF, "cb_32_32");
    rand_pix(30);

    // Press event lands on the frame_start cycle
    vsync = 1'b0; btn = 1'b1;
    repeat (6) tick();
    btn = 1'b0; vsync = 1'b1;
    tick();
    m_mode = (m_mode + 1) % 4; m_off = (m_off + STEP) % 640; m_pend = 1'b0;
    chk("simul_mode", 24'(mode), 24'd3);
    repeat (DEB + 6) tick();
    frame();
    chk("simul_nopend", 24'(mode), 24'd3);

    // Scroll up to offset 632, then across the wrap
    guard = 0;
    while (m_off != 632 && guard < 200) begin
      frame();
      rand_pix(2);
      guard++;
    end
    chk("scroll_reach", 24'(guard < 200), 24'd1);
    pix_k(0, 100, 1'b1, 24'h000000, "scr632_h0");
    pix_k(8, 100, 1'b1, 24'hFFFFFF, "scr632_h8");
    frame();
    pix_k(4, 100, 1'b1, 24'hFFFFFF, "scr636_h4");
    pix_k(3, 100, 1'b1, 24'h000000, "scr636_h3");
    frame();
    pix_k(0, 100, 1'b1, 24'hFFFFFF, "scr0_h0");
    pix_k(80, 100, 1'b1, 24'hFFFF00, "scr0_h80");
    pix_k(650, 100, 1'b1, 24'h000000, "scr_oor");

    // Mode 3 plus a press wraps to 0
    press(6);
    frame();
    chk("wrap_mode", 24'(mode), 24'd0);

    // Random button activity and pixels
    for (int k = 0; k < 24; k++) begin
      press($urandom_range(1, 8));
      if ($urandom_range(0, 1) != 0) press($urandom_range(1, 8));
      frame();
      rand_pix(8);
    end

    // Make sure mode is non-zero, then reset mid-frame
    if (m_mode == 0) begin press(6); frame(); end
    valid = 1'b1; h_addr = 10'd100; v_addr = 10'd100;
    @(posedge pclk); #7;
    reset = 1'b1;
    #3;
    chk("midrst_mode", 24'(mode), 24'd0);
    chk("midrst_data", vga_data, 24'h000000);
    vsync = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_reset();
    frame();
    chk("rst_frame_mode", 24'(mode), 24'd0);
    repeat (3) begin press(5); frame(); end
    pix_k(0, 10, 1'b1, 24'hFFFFFF, "rst_off_h0");
    pix_k(624, 10, 1'b1, 24'hFFFFFF, "rst_off_h624");
    pix_k(623, 10, 1'b1, 24'h000000, "rst_off_h623");
    rand_pix(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
